// File: rtl/spi_axi_write_arbiter.sv
// Two-master AXI write arbiter in front of a single SPI AXI slave.
// Optional watchdog: define SPI_ARB_WDT_EN.
module spi_axi_write_arbiter #(
  parameter int sword    = 32,
  parameter int wdt_bits = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             m0_awvalid,
  output logic             m0_awready,
  input  logic [sword-1:0] m0_awaddr,
  input  logic             m0_wvalid,
  output logic             m0_wready,
  input  logic [sword-1:0] m0_wdata,
  output logic             m0_bvalid,
  input  logic             m0_bready,
  input  logic             m1_awvalid,
  output logic             m1_awready,
  input  logic [sword-1:0] m1_awaddr,
  input  logic             m1_wvalid,
  output logic             m1_wready,
  input  logic [sword-1:0] m1_wdata,
  output logic             m1_bvalid,
  input  logic             m1_bready,
  output logic             s_awvalid,
  input  logic             s_awready,
  output logic [sword-1:0] s_awaddr,
  output logic             s_wvalid,
  input  logic             s_wready,
  output logic [sword-1:0] s_wdata,
  input  logic             s_bvalid,
  output logic             s_bready,
  output logic [1:0]       grant
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    RESP
  } state_t;

  state_t st, st_nx;

  logic [1:0] gnt;
  logic       last;
  logic       aw_pend, w_pend;
  logic       aw_nx, w_nx;
  logic       req0, req1;
  logic       sel_go, sel1;
  logic       mg_bready;
  logic       b_ok;
  logic       wdt_to;

  assign req0 = m0_awvalid & m0_wvalid;
  assign req1 = m1_awvalid & m1_wvalid;

  // m1 wins when alone, or on a tie when m0 was served last
  assign sel_go = (st == IDLE) & (req0 | req1);
  assign sel1   = req1 & (~req0 | ~last);

  assign m0_awready = RST & sel_go & ~sel1;
  assign m0_wready  = RST & sel_go & ~sel1;
  assign m1_awready = RST & sel_go & sel1;
  assign m1_wready  = RST & sel_go & sel1;

  assign mg_bready = gnt[1] ? m1_bready : m0_bready;
  assign b_ok      = (st == RESP) & ~wdt_to;

  assign s_awvalid = aw_pend & ~wdt_to;
  assign s_wvalid  = w_pend & ~wdt_to;
  assign s_bready  = b_ok & mg_bready;
  assign m0_bvalid = gnt[0] & ((b_ok & s_bvalid) | wdt_to);
  assign m1_bvalid = gnt[1] & ((b_ok & s_bvalid) | wdt_to);
  assign grant     = gnt;

  assign aw_nx = aw_pend & ~(s_awready & ~wdt_to);
  assign w_nx  = w_pend & ~(s_wready & ~wdt_to);

  // next-state: AW and W finish independently, then wait for B
  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE: if (sel_go) st_nx = SEND;
      SEND: begin
        if (wdt_to) begin
          if (mg_bready) st_nx = IDLE;
        end else if (!aw_nx && !w_nx) begin
          st_nx = RESP;
        end
      end
      RESP: begin
        if (wdt_to ? mg_bready : (s_bvalid & mg_bready))
          st_nx = IDLE;
      end
      default: st_nx = IDLE;
    endcase
  end

  // state, ownership, pending valids and captured address/data
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      st       <= IDLE;
      gnt      <= 2'b00;
      last     <= 1'b1;
      aw_pend  <= 1'b0;
      w_pend   <= 1'b0;
      s_awaddr <= '0;
      s_wdata  <= '0;
    end else begin
      st <= st_nx;
      if (sel_go) begin
        gnt      <= sel1 ? 2'b10 : 2'b01;
        aw_pend  <= 1'b1;
        w_pend   <= 1'b1;
        s_awaddr <= sel1 ? m1_awaddr : m0_awaddr;
        s_wdata  <= sel1 ? m1_wdata : m0_wdata;
      end else if (st_nx == IDLE) begin
        aw_pend <= 1'b0;
        w_pend  <= 1'b0;
      end else begin
        aw_pend <= aw_nx;
        w_pend  <= w_nx;
      end
      if (st != IDLE && st_nx == IDLE) begin
        gnt  <= 2'b00;
        last <= gnt[1];
      end
    end
  end

`ifdef SPI_ARB_WDT_EN
  localparam logic [wdt_bits-1:0] WPRE = {{(wdt_bits-1){1'b1}}, 1'b0};

  logic [wdt_bits-1:0] wcnt;

  // watchdog: count busy cycles; timeout flag rises as count hits all-ones
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wcnt   <= '0;
      wdt_to <= 1'b0;
    end else if (sel_go) begin
      wcnt   <= '0;
      wdt_to <= 1'b0;
    end else if (st_nx == IDLE) begin
      wdt_to <= 1'b0;
    end else if (st != IDLE) begin
      if (wcnt != '1) wcnt <= wcnt + 1'b1;
      if (wcnt == WPRE) wdt_to <= 1'b1;
    end
  end
`else
  assign wdt_to = 1'b0;
`endif

endmodule

// File: tb/tb_spi_axi_write_arbiter.sv
// Directed bench for spi_axi_write_arbiter.
// Slave-side W beats are checked against a queue of expected writes.
module tb_spi_axi_write_arbiter;

`ifdef SPI_ARB_WDT_EN
  localparam int WB = 4;
`else
  localparam int WB = 8;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        m0_awvalid, m0_awready, m0_wvalid, m0_wready;
  logic        m0_bvalid, m0_bready;
  logic [31:0] m0_awaddr, m0_wdata;
  logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready;
  logic        m1_bvalid, m1_bready;
  logic [31:0] m1_awaddr, m1_wdata;
  logic        s_awvalid, s_awready, s_wvalid, s_wready;
  logic        s_bvalid, s_bready;
  logic [31:0] s_awaddr, s_wdata;
  logic [1:0]  grant;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [1:0]  g;
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;

  exp_t sbq[$];

  always #5 CLK = ~CLK;

  spi_axi_write_arbiter #(.sword(32), .wdt_bits(WB)) dut (
    .CLK(CLK), .RST(RST),
    .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
    .m0_awaddr(m0_awaddr), .m0_wvalid(m0_wvalid),
    .m0_wready(m0_wready), .m0_wdata(m0_wdata),
    .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
    .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_awaddr(m1_awaddr), .m1_wvalid(m1_wvalid),
    .m1_wready(m1_wready), .m1_wdata(m1_wdata),
    .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_awaddr(s_awaddr), .s_wvalid(s_wvalid),
    .s_wready(s_wready), .s_wdata(s_wdata),
    .s_bvalid(s_bvalid), .s_bready(s_bready),
    .grant(grant)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic nedge();
    @(negedge CLK);
  endtask

  task automatic push(input logic [1:0] g, input logic [31:0] a,
                      input logic [31:0] d);
    exp_t e;
    e.g = g;
    e.a = a;
    e.d = d;
    sbq.push_back(e);
  endtask

  task automatic wait_sel(output logic [1:0] got, output int n);
    got = 2'b00;
    n = 0;
    while (got == 2'b00 && n < 100) begin
      @(negedge CLK);
      n++;
      if (m0_awready || m1_awready) got = {m1_awready, m0_awready};
    end
    if (got == 2'b00) begin
      total++;
      bad++;
      $display("FAIL sel_timeout: got none want a grant");
    end
  endtask

  // monitor: every slave W beat must match the next expected write
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RST && s_wvalid && s_wready) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: got data %h want none", s_wdata);
        end else begin
          e = sbq.pop_front();
          chk("sb_grant", {30'b0, grant}, {30'b0, e.g});
          chk("sb_addr", s_awaddr, e.a);
          chk("sb_data", s_wdata, e.d);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] got;
    logic [1:0] tie_exp [3];
    int n;
    int errs;
    tie_exp[0] = 2'b01;
    tie_exp[1] = 2'b10;
    tie_exp[2] = 2'b01;
    m0_awvalid = 0; m0_wvalid = 0; m0_bready = 1;
    m0_awaddr = 0; m0_wdata = 0;
    m1_awvalid = 0; m1_wvalid = 0; m1_bready = 1;
    m1_awaddr = 0; m1_wdata = 0;
    s_awready = 1; s_wready = 1; s_bvalid = 1;

    // reset state
    #12;
    chk("rst_grant", {30'b0, grant}, 32'h0);
    chkb("rst_awvalid", s_awvalid, 1'b0);
    chkb("rst_wvalid", s_wvalid, 1'b0);
    chkb("rst_bready", s_bready, 1'b0);
    chkb("rst_m0_bvalid", m0_bvalid, 1'b0);
    chk("rst_awaddr", s_awaddr, 32'h0);
    chk("rst_wdata", s_wdata, 32'h0);
    tick();
    RST = 1;
    tick();

    // ties: m0, m1, m0 with 3-cycle grant spacing
    push(2'b01, 32'h100, 32'h11111111);
    push(2'b10, 32'h200, 32'h22222222);
    push(2'b01, 32'h100, 32'h11111111);
    m0_awaddr = 32'h100; m0_wdata = 32'h11111111;
    m1_awaddr = 32'h200; m1_wdata = 32'h22222222;
    m0_awvalid = 1; m0_wvalid = 1;
    m1_awvalid = 1; m1_wvalid = 1;
    for (int i = 0; i < 3; i++) begin
      wait_sel(got, n);
      chk("tie_sel", {30'b0, got}, {30'b0, tie_exp[i]});
      if (i > 0) chk("tie_spacing", n, 3);
      tick();
      chk("tie_owner", {30'b0, grant}, {30'b0, tie_exp[i]});
    end
    m0_awvalid = 0; m0_wvalid = 0;
    m1_awvalid = 0; m1_wvalid = 0;
    repeat (4) tick();

    // m0 alone, B held back then passed through
    s_bvalid = 0;
    push(2'b01, 32'h10, 32'hA5A5A5A5);
    m0_awaddr = 32'h10; m0_wdata = 32'hA5A5A5A5;
    m0_awvalid = 1; m0_wvalid = 1;
    nedge();
    chkb("s1_awready", m0_awready, 1'b1);
    chkb("s1_wready", m0_wready, 1'b1);
    chkb("s1_m1_awready", m1_awready, 1'b0);
    tick();
    m0_awvalid = 0; m0_wvalid = 0;
    chk("s1_grant", {30'b0, grant}, 32'h1);
    nedge();
    chkb("s1_awready_one", m0_awready, 1'b0);
    chkb("s1_s_awvalid", s_awvalid, 1'b1);
    chkb("s1_s_wvalid", s_wvalid, 1'b1);
    chk("s1_s_wdata", s_wdata, 32'hA5A5A5A5);
    tick();
    nedge();
    chkb("s1_bvalid_lo", m0_bvalid, 1'b0);
    tick();
    s_bvalid = 1;
    nedge();
    chkb("s1_bvalid_hi", m0_bvalid, 1'b1);
    chkb("s1_m1_bvalid", m1_bvalid, 1'b0);
    chkb("s1_s_bready", s_bready, 1'b1);
    tick();
    nedge();
    chk("s1_grant_idle", {30'b0, grant}, 32'h0);
    tick();

    // W stalls 40 cycles while AW completes at once
    s_wready = 0;
    push(2'b10, 32'h44, 32'hDEADBEEF);
    m1_awaddr = 32'h44; m1_wdata = 32'hDEADBEEF;
    m1_awvalid = 1; m1_wvalid = 1;
    nedge();
    chkb("s3_m1_awready", m1_awready, 1'b1);
    tick();
    m1_awvalid = 0; m1_wvalid = 0;
    nedge();
    chkb("s3_awvalid_on", s_awvalid, 1'b1);
    tick();
    nedge();
    chkb("s3_awvalid_off", s_awvalid, 1'b0);
    chkb("s3_wvalid_on", s_wvalid, 1'b1);
    errs = 0;
    repeat (38) begin
      tick();
      nedge();
      if (!s_wvalid || m1_bvalid) errs++;
    end
    chk("s3_w_hold", errs, 0);
    tick();
    s_wready = 1;
    nedge();
    chkb("s3_wvalid_end", s_wvalid, 1'b1);
    tick();
    nedge();
    chkb("s3_resp", m1_bvalid, 1'b1);
    tick();
    tick();

    // m1 request held off while m0 sits in RESP
    s_bvalid = 0;
    push(2'b01, 32'h20, 32'h0000BEEF);
    push(2'b10, 32'h24, 32'h0000CAFE);
    m0_awaddr = 32'h20; m0_wdata = 32'h0000BEEF;
    m0_awvalid = 1; m0_wvalid = 1;
    nedge();
    chkb("s4_m0_awready", m0_awready, 1'b1);
    tick();
    m0_awvalid = 0; m0_wvalid = 0;
    tick();
    m1_awaddr = 32'h24; m1_wdata = 32'h0000CAFE;
    m1_awvalid = 1; m1_wvalid = 1;
    errs = 0;
    repeat (5) begin
      nedge();
      if (m1_awready) errs++;
      tick();
    end
    chk("s4_hold", errs, 0);
    s_bvalid = 1;
    nedge();
    chkb("s4_m0_bvalid", m0_bvalid, 1'b1);
    chkb("s4_m1_awready_b", m1_awready, 1'b0);
    tick();
    nedge();
    chkb("s4_m1_awready_after", m1_awready, 1'b1);
    tick();
    m1_awvalid = 0; m1_wvalid = 0;
    chk("s4_grant", {30'b0, grant}, 32'h2);
    repeat (4) tick();

    // reset pulse in SEND, then m1 served normally
    s_awready = 0; s_wready = 0;
    m0_awaddr = 32'h28; m0_wdata = 32'h55555555;
    m0_awvalid = 1; m0_wvalid = 1;
    nedge();
    chkb("s5_m0_awready", m0_awready, 1'b1);
    tick();
    m0_awvalid = 0; m0_wvalid = 0;
    nedge();
    chkb("s5_send", s_awvalid, 1'b1);
    tick();
    m1_awaddr = 32'h30; m1_wdata = 32'h12345678;
    m1_awvalid = 1; m1_wvalid = 1;
    RST = 0;
    #1;
    chkb("s5_awvalid", s_awvalid, 1'b0);
    chkb("s5_wvalid", s_wvalid, 1'b0);
    chk("s5_grant", {30'b0, grant}, 32'h0);
    chkb("s5_m1_awready", m1_awready, 1'b0);
    chkb("s5_m0_bvalid", m0_bvalid, 1'b0);
    chk("s5_awaddr", s_awaddr, 32'h0);
    nedge();
    chkb("s5_m1_awready_rst", m1_awready, 1'b0);
    tick();
    push(2'b10, 32'h30, 32'h12345678);
    s_awready = 1; s_wready = 1;
    RST = 1;
    nedge();
    chkb("s5_m1_sel", m1_awready, 1'b1);
    chkb("s5_m0_nsel", m0_awready, 1'b0);
    tick();
    m1_awvalid = 0; m1_wvalid = 0;
    chk("s5_grant_m1", {30'b0, grant}, 32'h2);
    n = 0;
    got = 2'b00;
    while (got == 2'b00 && n < 20) begin
      nedge();
      n++;
      if (m1_bvalid) got = 2'b10;
    end
    chk("s5_m1_bvalid", {30'b0, got}, 32'h2);
    repeat (3) tick();

`ifdef SPI_ARB_WDT_EN
    // watchdog: B never comes, timeout response 15 cycles after SEND entry
    s_bvalid = 0;
    push(2'b01, 32'h50, 32'h0F0F0F0F);
    m0_awaddr = 32'h50; m0_wdata = 32'h0F0F0F0F;
    m0_awvalid = 1; m0_wvalid = 1;
    nedge();
    chkb("s6_m0_awready", m0_awready, 1'b1);
    tick();
    m0_awvalid = 0; m0_wvalid = 0;
    repeat (14) tick();
    nedge();
    chkb("s6_bvalid_early", m0_bvalid, 1'b0);
    tick();
    nedge();
    chkb("s6_bvalid_to", m0_bvalid, 1'b1);
    chkb("s6_s_bready", s_bready, 1'b0);
    chkb("s6_s_awvalid", s_awvalid, 1'b0);
    tick();
    nedge();
    chk("s6_idle", {30'b0, grant}, 32'h0);
    chkb("s6_bvalid_off", m0_bvalid, 1'b0);
    s_bvalid = 1;
    repeat (2) tick();
`endif

    repeat (3) tick();
    chk("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_axi_write_arbiter.md
SPI_AXI_WRITE_ARBITER -- requirements
Module: spi_axi_write_arbiter

Interface
REQ-001 The block SHALL have these parameters:
- sword, default 32: address and data width.
- wdt_bits, default 8: watchdog counter width.
REQ-002 The block SHALL have these ports (N = 0, 1):
- CLK  input  1  single clock, rising edge.
- RST  input  1  asynchronous, active-low reset.
- mN_awvalid  input  1  master N write-address valid.
- mN_awready  output  1  master N write-address ready.
- mN_awaddr  input  sword  master N write address.
- mN_wvalid  input  1  master N write-data valid.
- mN_wready  output  1  master N write-data ready.
- mN_wdata  input  sword  master N write data.
- mN_bvalid  output  1  master N write-response valid.
- mN_bready  input  1  master N write-response ready.
- s_awvalid  output  1  write-address valid to the SPI AXI slave.
- s_awready  input  1  write-address ready from the SPI AXI slave.
- s_awaddr  output  sword  captured address.
- s_wvalid  output  1  write-data valid to the SPI AXI slave.
- s_wready  input  1  write-data ready from the SPI AXI slave.
- s_wdata  output  sword  captured data.
- s_bvalid  input  1  write response from the SPI AXI slave.
- s_bready  output  1  write-response ready to the SPI AXI slave.
- grant  output  2  one-hot current owner; 00 when idle.

Function
REQ-003 Master N SHALL request only when both mN_awvalid and mN_wvalid are 1 in the same cycle.
REQ-004 The FSM SHALL have three states: IDLE, SEND and RESP.
REQ-005 In IDLE with exactly one requester, that master SHALL be selected.
REQ-006 In IDLE with both masters requesting, the master not served last SHALL be selected (round-robin); the first tie after reset SHALL go to m0.
REQ-007 In the selection cycle, for the selected master G:
- mG_awready and mG_wready SHALL be 1 (combinational).
- mG_awaddr and mG_wdata SHALL be registered into s_awaddr and s_wdata.
- grant SHALL become one-hot G on the next edge.
- The state SHALL move to SEND.
REQ-008 The unselected master's awready and wready SHALL be 0 in every cycle.
REQ-009 In SEND, s_awvalid and s_wvalid SHALL both be 1 on entry; each SHALL drop independently after its ready handshake; when both have completed, the state SHALL move to RESP.
REQ-010 Latency from the selection edge to s_awvalid = s_wvalid = 1 SHALL be exactly one cycle.
REQ-011 In RESP, mG_bvalid SHALL equal s_bvalid, s_bready SHALL equal mG_bready, and the other master's bvalid SHALL be 0.
REQ-012 The s_bvalid and mG_bready handshake SHALL:
- return the state to IDLE;
- record G as last served;
- set grant to 00.
REQ-013 A new selection SHALL NOT occur in the same cycle as the RESP exit; minimum spacing between grants SHALL be 3 cycles.
REQ-014 Requests arriving in SEND or RESP SHALL be held off (ready = 0) and not dropped; masters keep valid asserted per AXI rules.
REQ-015 s_awaddr and s_wdata SHALL hold their value until the next selection.

Reset
REQ-016 While RST = 0, asynchronously:
- state SHALL be IDLE;
- last-served SHALL be m1, so m0 wins the first tie;
- grant SHALL be 00;
- all valid, ready and bvalid outputs SHALL be 0;
- s_awaddr and s_wdata SHALL be 0.
REQ-017 Reset asserted mid-transfer SHALL abandon the transfer with no response to either master.

Configuration
REQ-018 With macro SPI_ARB_WDT_EN defined:
- A wdt_bits counter SHALL clear on entry to SEND and increment every cycle in SEND and RESP.
- When the counter reaches all-ones, s_awvalid, s_wvalid and s_bready SHALL go to 0.
- mG_bvalid SHALL then be driven 1 from a register until mG_bready, after which the state returns to IDLE.
REQ-019 Without SPI_ARB_WDT_EN, there SHALL be no counter, and SEND and RESP SHALL wait indefinitely.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- m0 only writes 0xA5A5A5A5 to address 0x10 -> m0_awready = m0_wready = 1 for one cycle; s_wdata = 0xA5A5A5A5 with s_wvalid the next cycle; grant = 01; m0_bvalid follows s_bvalid.
- m0 and m1 request together, three times -> grants m0, m1, m0.
- s_wready held 0 for 40 cycles with s_awready = 1 -> s_awvalid drops after 1 cycle; s_wvalid stays 1 until s_wready; then RESP.
- m1 requests while m0 is in RESP -> m1_awready = 0 until at least 1 cycle after m0's B handshake.
- RST pulsed low during SEND -> all outputs 0 immediately; the next m1 request is served normally.
- SPI_ARB_WDT_EN with wdt_bits = 4 and s_bvalid never asserted -> m0_bvalid = 1 at 15 cycles after SEND entry; state returns to IDLE after m0_bready.
